// File: rtl/div_bus_if.sv
// Bus front end for the 16-bit sequential divider: operand/control/status/result
// registers, single-cycle launch, done/timeout tracking. `define DIV_IRQ_EN adds the irq output.
module div_bus_if #(
  parameter int          TIMEOUT     = 64,
  parameter logic [31:0] ZERO_RESULT = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] d_in,
  output logic [31:0] d_out,
  output logic        div_init,
  output logic [15:0] div_op_A,
  output logic [15:0] div_op_B,
  input  logic        div_done,
  input  logic [31:0] div_result,
  output logic        irq
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [2:0] R_OPA    = 3'd0;
  localparam logic [2:0] R_OPB    = 3'd1;
  localparam logic [2:0] R_CTRL   = 3'd2;
  localparam logic [2:0] R_STATUS = 3'd3;
  localparam logic [2:0] R_RESULT = 3'd4;

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [31:0] result;
  logic        done;
  logic        dz;
  logic        tmo;
  logic        ie;
  logic        busy;

  logic [2:0]  sel;
  logic        bus_wr;
  logic        bus_rd;
  logic        wr_ctrl;
  logic        start;
  logic        rd_result;
  logic        unused_bits;

  assign sel       = addr[4:2];
  assign bus_wr    = cs & wr;
  assign bus_rd    = cs & rd;
  assign busy      = (state != S_IDLE);
  assign wr_ctrl   = bus_wr && (sel == R_CTRL);
  assign start     = wr_ctrl && d_in[0] && !busy;
  assign rd_result = bus_rd && (sel == R_RESULT);

  assign div_init  = (state == S_LAUNCH);
  assign div_op_A  = opa;
  assign div_op_B  = opb;

  assign unused_bits = ^{addr[1:0], d_in[31:16], d_in[1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      tmo_cnt <= 8'd0;
      opa     <= 16'd0;
      opb     <= 16'd0;
      result  <= 32'd0;
      done    <= 1'b0;
      dz      <= 1'b0;
      tmo     <= 1'b0;
    end else begin
      // Operands are frozen while an operation is in flight.
      if (bus_wr && (sel == R_OPA) && !busy) opa <= d_in[15:0];
      if (bus_wr && (sel == R_OPB) && !busy) opb <= d_in[15:0];
      // Clear-on-read first so a same-edge set from the FSM below wins.
      if (rd_result) done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            done <= 1'b0;
            dz   <= 1'b0;
            tmo  <= 1'b0;
            if (opb == 16'd0) begin
              result <= ZERO_RESULT;
              dz     <= 1'b1;
              done   <= 1'b1;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= 8'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            result <= div_result;
            done   <= 1'b1;
            state  <= S_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            tmo   <= 1'b1;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DIV_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (wr_ctrl) ie <= d_in[1];
      irq <= done & ie;
    end
  end
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_out <= 32'd0;
    end else if (bus_rd) begin
      case (sel)
        R_OPA:    d_out <= {16'd0, opa};
        R_OPB:    d_out <= {16'd0, opb};
        R_CTRL:   d_out <= {30'd0, ie, 1'b0};
        R_STATUS: d_out <= {28'd0, tmo, dz, done, busy};
        R_RESULT: d_out <= result;
        default:  d_out <= 32'd0;
      endcase
    end else begin
      d_out <= 32'd0;
    end
  end

endmodule

// File: tb/tb_div_bus_if.sv
// Bench for div_bus_if: bus driver tasks, divider model, read scoreboard, direct pin checks.
module tb_div_bus_if;

  localparam int          TIMEOUT = 64;
  localparam logic [31:0] ZR      = 32'hFFFF_FFFF;
`ifdef DIV_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam logic [4:0] A_OPA  = 5'h00;
  localparam logic [4:0] A_OPB  = 5'h04;
  localparam logic [4:0] A_CTRL = 5'h08;
  localparam logic [4:0] A_STAT = 5'h0C;
  localparam logic [4:0] A_RES  = 5'h10;
  localparam logic [4:0] A_NONE = 5'h14;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [4:0]  addr;
  logic [31:0] d_in;
  logic [31:0] d_out;
  logic        div_init;
  logic [15:0] div_op_A;
  logic [15:0] div_op_B;
  logic        div_done;
  logic [31:0] div_result;
  logic        irq;

  div_bus_if #(.TIMEOUT(TIMEOUT), .ZERO_RESULT(ZR)) dut (
    .clk(clk), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .div_init(div_init), .div_op_A(div_op_A),
    .div_op_B(div_op_B), .div_done(div_done), .div_result(div_result), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          init_cnt = 0;
  logic        rd_flag = 1'b0;
  logic        model_en = 1'b1;
  int          late_req = 0;
  int          late_ack = 0;
  logic [31:0] m_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: remainder in the upper half, quotient in the lower half.
  function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] q;
    logic [15:0] r;
    if (b == 16'd0) return ZR;
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 32'd0;
  endtask

  task automatic bus_read(input logic [4:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; rd = 1'b1; addr = a;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic load_and_start(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ctrl);
    bus_write(A_OPA, {16'd0, a});
    bus_write(A_OPB, {16'd0, b});
    bus_write(A_CTRL, ctrl);
  endtask

  // ---------------- read monitor ----------------
  always @(posedge clk) rd_flag <= cs & rd;

  always @(negedge clk) begin
    if (rd_flag) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", d_out, 32'hxxxx_xxxx);
      end else begin
        check(name_q.pop_front(), d_out, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) if (div_init) init_cnt++;

  // ---------------- divider model: done 40 cycles after init ----------------
  initial begin
    logic [15:0] a;
    logic [15:0] b;
    div_done = 1'b0;
    div_result = 32'd0;
    forever begin
      @(negedge clk);
      if (div_init && model_en) begin
        a = div_op_A;
        b = div_op_B;
        repeat (40) @(posedge clk);
        #1;
        div_done = 1'b1;
        div_result = (b == 16'd0) ? 32'd0 : {a % b, a / b};
        @(posedge clk);
        #1;
        div_done = 1'b0;
        div_result = 32'd0;
      end else if (late_req != late_ack) begin
        div_done = 1'b1;
        div_result = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        div_done = 1'b0;
        div_result = 32'd0;
        late_ack = late_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int ic;
    logic [15:0] ra;
    logic [15:0] rb;
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 5'd0; d_in = 32'd0;
    m_result = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_d_out", d_out, 32'd0);
    check("rst_div_init", {31'd0, div_init}, 32'd0);
    check("rst_op_a", {16'd0, div_op_A}, 32'd0);
    check("rst_op_b", {16'd0, div_op_B}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    bus_read(A_STAT, 32'd0, "rst_status");
    bus_read(A_RES,  32'd0, "rst_result");
    bus_read(A_OPA,  32'd0, "rst_opa");
    bus_read(A_CTRL, 32'd0, "rst_ctrl");
    bus_read(A_NONE, 32'd0, "unmapped_read");

    // Basic 100/7
    ic = init_cnt;
    load_and_start(16'd100, 16'd7, 32'h1);
    idle(4);
    bus_read(A_STAT, 32'h1, "basic_busy");
    idle(45);
    m_result = ref_div(16'd100, 16'd7);
    bus_read(A_STAT, 32'h2, "basic_done");
    check("basic_init_pulses", init_cnt - ic, 1);
    bus_read(A_RES, m_result, "basic_result");
    bus_read(A_STAT, 32'h0, "basic_done_cleared");

    // Divide by zero
    ic = init_cnt;
    load_and_start(16'd5, 16'd0, 32'h1);
    idle(2);
    check("dz_no_init", init_cnt - ic, 0);
    m_result = ref_div(16'd5, 16'd0);
    bus_read(A_STAT, 32'h6, "dz_status");
    bus_read(A_RES, m_result, "dz_result");
    bus_read(A_STAT, 32'h4, "dz_status_after_read");

    // Protection: operand write and second start during busy
    ic = init_cnt;
    load_and_start(16'd100, 16'd7, 32'h1);
    idle(3);
    bus_write(A_OPA, 32'd9);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_OPA, 32'd100, "prot_opa");
    idle(45);
    m_result = ref_div(16'd100, 16'd7);
    bus_read(A_STAT, 32'h2, "prot_status");
    bus_read(A_RES, m_result, "prot_result");
    check("prot_init_pulses", init_cnt - ic, 1);

    // Randomized operands
    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = (i < 2) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      bus_write(A_OPA, {16'd0, ra});
      bus_write(A_OPB, {16'd0, rb});
      bus_read(A_OPA, {16'd0, ra}, "rand_opa");
      bus_read(A_OPB, {16'd0, rb}, "rand_opb");
      bus_write(A_CTRL, 32'h1);
      idle(48);
      m_result = ref_div(ra, rb);
      bus_read(A_STAT, 32'h2, "rand_status");
      bus_read(A_RES, m_result, "rand_result");
    end

    // Timeout: divider never answers
    model_en = 1'b0;
    ic = init_cnt;
    load_and_start(16'd1234, 16'd10, 32'h1);
    idle(TIMEOUT - 1);
    bus_read(A_STAT, 32'h1, "tmo_busy_late");
    bus_read(A_STAT, 32'h1, "tmo_busy_last");
    bus_read(A_STAT, 32'hA, "tmo_status");
    late_req++;
    idle(5);
    bus_read(A_RES, m_result, "tmo_result_kept");
    bus_read(A_STAT, 32'h8, "tmo_status_after_read");
    check("tmo_init_pulses", init_cnt - ic, 1);
    model_en = 1'b1;

    // Asynchronous reset in the middle of WAIT
    load_and_start(16'd100, 16'd7, 32'h1);
    idle(5);
    bus_read(A_OPA, 32'd100, "mid_opa");
    #1 reset = 1'b1;
    #1;
    check("async_d_out", d_out, 32'd0);
    check("async_div_init", {31'd0, div_init}, 32'd0);
    check("async_op_a", {16'd0, div_op_A}, 32'd0);
    check("async_op_b", {16'd0, div_op_B}, 32'd0);
    check("async_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_result = 32'd0;
    idle(45);
    bus_read(A_STAT, 32'd0, "post_rst_status");
    bus_read(A_RES, m_result, "post_rst_result");
    bus_read(A_OPA, 32'd0, "post_rst_opa");

    // Interrupt: 300/10 with ie set
    load_and_start(16'd300, 16'd10, 32'h3);
    bus_read(A_CTRL, {30'd0, IRQ_ON, 1'b0}, "irq_ctrl_read");
    idle(40);
    check("irq_before", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});
    m_result = ref_div(16'd300, 16'd10);
    bus_read(A_RES, m_result, "irq_result");
    check("irq_hold", {31'd0, irq}, {31'd0, IRQ_ON});
    idle(1);
    check("irq_fall_read", {31'd0, irq}, 32'd0);

    // Interrupt dropped by an ie=0 write
    load_and_start(16'd300, 16'd10, 32'h3);
    idle(43);
    check("irq_rise2", {31'd0, irq}, {31'd0, IRQ_ON});
    bus_write(A_CTRL, 32'h0);
    check("irq_hold2", {31'd0, irq}, {31'd0, IRQ_ON});
    idle(1);
    check("irq_fall_ie", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, 32'h2, "irq_status_done");

    idle(5);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
